// File: rtl/clk_freq_monitor.sv
// Counts rising edges of an asynchronous clock over fixed clk_in windows and
// tracks lock/fault. Optional: CLK_FREQ_MONITOR_AUTORECOVER_EN (good window in FAULT -> ACQUIRE).
`timescale 1ns/1ps
module clk_freq_monitor #(
  parameter int WINDOW     = 1024,
  parameter int EXPECTED   = 256,
  parameter int TOL        = 2,
  parameter int LOCK_COUNT = 4
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        clk_mon,
  input  logic        enable,
  input  logic        clear_fault,
  output logic [15:0] meas_count,
  output logic        meas_valid,
  output logic        locked,
  output logic        fault,
  output logic [1:0]  state
);
  localparam int WW = $clog2(WINDOW);
  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam logic [31:0] LO_U   = (EXPECTED > TOL) ? 32'(EXPECTED - TOL) : 32'd0;
  localparam logic [31:0] HI_U   = 32'(EXPECTED + TOL);
  localparam logic [31:0] LOCK_U = 32'(LOCK_COUNT);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2, FAULT = 2'd3} state_t;

  state_t        st;
  logic          sync1, sync2, sync3;
  logic [WW-1:0] win_cnt;
  logic [15:0]   edge_cnt, cnt_final;
  logic [RW-1:0] run_cnt, run_inc;
  logic          rise, win_end, good, lock_hit;

  assign rise      = sync2 & ~sync3;
  assign win_end   = (win_cnt == WIN_LAST);
  // An edge detected in the terminal cycle still belongs to the closing window.
  assign cnt_final = (rise && edge_cnt != 16'hFFFF) ? edge_cnt + 16'd1 : edge_cnt;
  assign good      = (32'(cnt_final) >= LO_U) && (32'(cnt_final) <= HI_U);
  assign run_inc   = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RW'(1);
  assign lock_hit  = (32'(run_inc) >= LOCK_U);

  assign state  = st;
  assign locked = (st == LOCKED);
  assign fault  = (st == FAULT);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      st         <= IDLE;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      run_cnt    <= '0;
      meas_count <= '0;
      meas_valid <= 1'b0;
    end else begin
      sync1      <= clk_mon;
      sync2      <= sync1;
      sync3      <= sync2;
      meas_valid <= 1'b0;
      if (st == IDLE) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
        run_cnt  <= '0;
        if (enable) st <= ACQUIRE;
      end else if (!enable) begin
        st       <= IDLE;
        win_cnt  <= '0;
        edge_cnt <= '0;
        run_cnt  <= '0;
      end else begin
        if (win_end) begin
          win_cnt    <= '0;
          edge_cnt   <= '0;
          meas_count <= cnt_final;
          meas_valid <= 1'b1;
        end else begin
          win_cnt  <= win_cnt + WW'(1);
          edge_cnt <= cnt_final;
        end
        // clear_fault restarts the window and discards a coincident result
        if (st == FAULT && clear_fault) begin
          st       <= ACQUIRE;
          run_cnt  <= '0;
          win_cnt  <= '0;
          edge_cnt <= '0;
        end else if (win_end) begin
          case (st)
            ACQUIRE: begin
              run_cnt <= good ? run_inc : '0;
              if (good && lock_hit) st <= LOCKED;
            end
            LOCKED: begin
              run_cnt <= good ? run_inc : '0;
              if (!good) st <= FAULT;
            end
            default: begin
`ifdef CLK_FREQ_MONITOR_AUTORECOVER_EN
              if (good) begin
                st      <= ACQUIRE;
                run_cnt <= RW'(1);
              end else begin
                run_cnt <= '0;
              end
`else
              run_cnt <= good ? run_inc : '0;
`endif
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_clk_freq_monitor.sv
// Randomized bench for clk_freq_monitor: window-level reference model fed by
// timestamps of the clk_mon rising edges the bench generates.
`timescale 1ns/1ps
module tb_clk_freq_monitor;
  localparam int WINDOW = 1024, EXPECTED = 256, TOL = 2, LOCK_COUNT = 4;
  localparam int W_LOCK = 0, W_FAULT = 1, W_ACQ = 2, W_VALID = 3;

  logic        clk_in, reset_n, clk_mon, enable, clear_fault;
  logic [15:0] meas_count;
  logic        meas_valid, locked, fault;
  logic [1:0]  state;

  clk_freq_monitor #(.WINDOW(WINDOW), .EXPECTED(EXPECTED), .TOL(TOL), .LOCK_COUNT(LOCK_COUNT)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .clk_mon(clk_mon), .enable(enable),
    .clear_fault(clear_fault), .meas_count(meas_count), .meas_valid(meas_valid),
    .locked(locked), .fault(fault), .state(state)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int errors = 0, checks = 0;
  int cyc = 0;
  int mon_period = 0;
  int rq[$];
  int m_st = 0, m_run = 0, m_S = 0;
  logic [15:0] m_meas = '0;
  bit m_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // clk_mon generator: period changes take effect only at a period boundary
  initial begin
    int ph, cur;
    bit nv;
    ph = 0; cur = 0; clk_mon = 1'b0;
    forever begin
      @(negedge clk_in);
      if (cur == 0 || ph == cur - 1) begin cur = mon_period; ph = 0; end
      else ph++;
      nv = (cur != 0) && (ph < cur / 2);
      if (nv && !clk_mon) rq.push_back(cyc + 1);
      clk_mon = nv;
    end
  end

  // Reference model: an edge first sampled at posedge n counts at posedge n+2;
  // a window started at posedge S covers posedges S+1..S+WINDOW.
  initial begin
    int cnt;
    bit wend, good;
    forever begin
      @(posedge clk_in or negedge reset_n);
      if (!reset_n) begin
        m_st = 0; m_run = 0; m_S = 0; m_meas = '0; m_valid = 1'b0;
      end else begin
        cyc++;
        m_valid = 1'b0;
        if (m_st == 0) begin
          if (enable) begin m_st = 1; m_S = cyc; m_run = 0; end
        end else if (!enable) begin
          m_st = 0; m_run = 0;
        end else begin
          wend = (cyc == m_S + WINDOW);
          good = 1'b0;
          if (wend) begin
            cnt = 0;
            foreach (rq[i]) if (rq[i] + 2 > m_S && rq[i] + 2 <= cyc) cnt++;
            while (rq.size() > 0 && rq[0] + 2 <= cyc) void'(rq.pop_front());
            if (cnt > 65535) cnt = 65535;
            m_meas = 16'(cnt);
            m_valid = 1'b1;
            m_S = cyc;
            good = (cnt >= EXPECTED - TOL) && (cnt <= EXPECTED + TOL);
          end
          if (m_st == 3 && clear_fault) begin
            m_st = 1; m_run = 0; m_S = cyc;
          end else if (wend) begin
            if (m_st == 1) begin
              m_run = good ? m_run + 1 : 0;
              if (m_run >= LOCK_COUNT) m_st = 2;
            end else if (m_st == 2) begin
              if (!good) m_st = 3;
            end else begin
`ifdef CLK_FREQ_MONITOR_AUTORECOVER_EN
              if (good) begin m_st = 1; m_run = 1; end
`endif
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison of the control outputs against the model
  initial begin
    forever begin
      @(negedge clk_in);
      if (reset_n) begin
        check("ctl", {27'd0, state, locked, fault, meas_valid},
              {27'd0, 2'(m_st), m_st == 2, m_st == 3, m_valid});
        if (meas_valid || m_valid || (cyc % 128) == 0)
          check("meas", 32'(meas_count), 32'(m_meas));
      end
    end
  end

  function automatic logic hit(input int w);
    case (w)
      W_LOCK:  return locked;
      W_FAULT: return fault;
      W_ACQ:   return state == 2'd1;
      default: return meas_valid;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int what, input int maxc, output int n);
    n = 0;
    do begin @(negedge clk_in); n++; end while (!hit(what) && n < maxc);
    check({tag, "_hit"}, 32'(hit(what)), 1);
  endtask

  task automatic wait_win_pos(input int pos);
    int n;
    n = 0;
    while (cyc != m_S + pos && n < 2 * WINDOW) begin @(negedge clk_in); n++; end
    check("win_pos", 32'(cyc - m_S), 32'(pos));
  endtask

  task automatic pulse_clear();
    clear_fault = 1'b1;
    @(negedge clk_in);
    clear_fault = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_meas"}, 32'(meas_count), 0);
    check({tag, "_valid"}, 32'(meas_valid), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_fault"}, 32'(fault), 0);
    check({tag, "_state"}, 32'(state), 0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; enable = 1'b0; clear_fault = 1'b0; mon_period = 0;
    repeat (3) @(negedge clk_in);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    mon_period = 4;
    repeat ($urandom_range(5, 40)) @(negedge clk_in);

    // 25 MHz: lock on the 4th window
    enable = 1'b1;
    wait_for("lock1", W_LOCK, 5 * WINDOW, n);
    check("lock_lat", 32'(n), 32'(4 * WINDOW + 1));

    // 20 MHz: one bad window faults
    mon_period = 5;
    wait_for("fault1", W_FAULT, 3 * WINDOW, n);
    check("meas_20m", 32'(meas_count == 16'd204 || meas_count == 16'd205), 1);

    // clear_fault coinciding with the next window end
    mon_period = 4;
    wait_win_pos(WINDOW - 1);
    pulse_clear();
    check("cf_state", 32'(state), 1);
    check("cf_valid", 32'(meas_valid), 1);
    wait_for("relock", W_LOCK, 5 * WINDOW, n);
    check("relock_lat", 32'(n), 32'(4 * WINDOW));

`ifdef CLK_FREQ_MONITOR_AUTORECOVER_EN
    mon_period = 5;
    wait_for("fault_ar", W_FAULT, 3 * WINDOW, n);
    mon_period = 4;
    wait_for("auto_acq", W_ACQ, 2 * WINDOW + 8, n);
    wait_for("auto_lock", W_LOCK, 4 * WINDOW, n);
    check("auto_lock_lat", 32'(n), 32'(3 * WINDOW));
`endif

    // clear_fault outside FAULT has no effect
    repeat (4) begin
      repeat ($urandom_range(20, 200)) @(negedge clk_in);
      pulse_clear();
    end
    check("cf_ignored", 32'(state), 2);

    // enable low together with clear_fault in FAULT -> IDLE, meas held
    mon_period = 5;
    wait_for("fault2", W_FAULT, 3 * WINDOW, n);
    enable = 1'b0;
    pulse_clear();
    check("off_state", 32'(state), 0);
    check("off_hold", 32'(meas_count), 32'(m_meas));

    // stuck clock: zero counts, stays in ACQUIRE
    mon_period = 0;
    repeat (10) @(negedge clk_in);
    enable = 1'b1;
    repeat (3 * WINDOW + 10) @(negedge clk_in);
    check("stuck_state", 32'(state), 1);
    check("stuck_meas", 32'(meas_count), 0);
    check("stuck_flags", {30'd0, locked, fault}, 0);

    // abort a window mid-way and restart
    mon_period = 4;
    wait_win_pos($urandom_range(100, 900));
    enable = 1'b0;
    repeat ($urandom_range(2, 30)) @(negedge clk_in);
    enable = 1'b1;
    wait_for("reen", W_VALID, 2 * WINDOW, n);
    check("reen_lat", 32'(n), 32'(WINDOW + 1));

    // asynchronous reset while locked
    wait_for("lock3", W_LOCK, 5 * WINDOW, n);
    repeat ($urandom_range(100, 900)) @(negedge clk_in);
    #2 reset_n = 1'b0;
    enable = 1'b0;
    #1 check_reset_outputs("arst");
    @(negedge clk_in);
    reset_n = 1'b1;
    repeat (20) @(negedge clk_in);
    check("post_rst_idle", 32'(state), 0);
    enable = 1'b1;
    @(negedge clk_in);
    check("post_rst_acq", 32'(state), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clk_freq_monitor.md
# clk_freq_monitor

Clock-frequency monitor on the consuming side of the 100 MHz to 25 MHz divider. It samples the divided clock in the `clk_in` domain and counts its rising edges over fixed reference windows. It then declares the clock locked or faulted. Pixel/video logic uses `locked` to gate start-up, and system logic uses `fault` to detect a stalled or mis-divided clock.

## Interface
- `WINDOW`, default 1024: `clk_in` cycles per measurement window; must be ≥ 4.
- `EXPECTED`, default 256: expected monitored rising edges per window.
- `TOL`, default 2: allowed absolute deviation from `EXPECTED`.
- `LOCK_COUNT`, default 4: consecutive good windows required to declare lock; must be ≥ 1.
- `clk_in`, input, 1: 100 MHz reference clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `clk_mon`, input, 1: monitored clock (e.g. the 25 MHz divider output); treated as asynchronous.
- `enable`, input, 1: run the monitor; low forces IDLE.
- `clear_fault`, input, 1: single-cycle pulse; leaves FAULT.
- `meas_count`, output, 16: edge count of the last completed window.
- `meas_valid`, output, 1: one-cycle pulse when `meas_count` updates.
- `locked`, output, 1: high in LOCKED.
- `fault`, output, 1: high in FAULT.
- `state`, output, 2: current state, encoded IDLE=0, ACQUIRE=1, LOCKED=2, FAULT=3.

## Operation
- `clk_mon` passes through a 2-flop synchronizer and then an edge-detect flop. A rising edge is `sync2 & ~sync3`. Each high and low phase of `clk_mon` must last at least 2 `clk_in` periods.
- Edge counter: 16-bit, saturates at 0xFFFF, never wraps.
- Window counter: runs 0..`WINDOW-1` while not IDLE. At the terminal cycle:
  - the edge count, including an edge detected in that same cycle, is latched into `meas_count`;
  - the edge counter restarts at 0;
  - the window counter restarts at 0.
- A window is good when `EXPECTED-TOL ≤ count ≤ EXPECTED+TOL`, compared unsigned with the lower bound clamped at 0.
- Good-run counter: increments on each good window and clears on each bad window.
- State machine:
  - IDLE: counters held at 0. `enable`=1 moves to ACQUIRE, and the window starts on the next cycle.
  - ACQUIRE: when the good-run count reaches `LOCK_COUNT`, move to LOCKED. Bad windows only clear the good-run count.
  - LOCKED: one bad window moves to FAULT.
  - FAULT: measurement continues. `clear_fault` moves to ACQUIRE, clears the good-run count and restarts the window.
- From any non-IDLE state, `enable`=0 moves to IDLE on the next cycle. The good-run, window and edge counters are cleared. `meas_count` keeps its last value.
- Simultaneous events:
  - `clear_fault` together with a window end: `clear_fault` wins and that window's result is discarded, but `meas_count` and `meas_valid` still update.
  - `enable`=0 together with `clear_fault`: the block goes to IDLE.
  - `clear_fault` outside FAULT is ignored.

## Timing
- Reset values:
  - outputs: `meas_count`=0, `meas_valid`=0, `locked`=0, `fault`=0, `state`=IDLE;
  - internals: synchronizer flops and all counters at 0.
- Edge-to-count latency: 3 `clk_in` cycles from a `clk_mon` rising edge to the edge-counter increment.
- `meas_valid`, `meas_count`, `state`, `locked` and `fault` all update on the clock edge ending the terminal window cycle, so they change together.
- First window after `enable` rises: `meas_valid` is observed `WINDOW`+1 cycles after `enable` is sampled high.
- Asserting `reset_n` mid-window immediately aborts the window and returns all outputs to reset values. Release is synchronized externally.

## Configuration
- `CLK_FREQ_MONITOR_AUTORECOVER_EN`:
  - Defined: in FAULT, a good window moves the block to ACQUIRE with the good-run count set to 1. `clear_fault` still works.
  - Undefined: FAULT is left only via `clear_fault`, `enable`=0, or reset.

## Test plan
All scenarios use the defaults (`WINDOW`=1024, `EXPECTED`=256, `TOL`=2, `LOCK_COUNT`=4).
- 25 MHz `clk_mon`, `enable` raised → every `meas_count` is 255..257; `locked`=1 coinciding with the 4th `meas_valid`, about 4097 cycles after `enable`.
- Locked, then `clk_mon` switched to 20 MHz (5-cycle period) → next full window `meas_count`=204 or 205, `fault`=1, `locked`=0, `state`=3.
- From FAULT, restore 25 MHz and pulse `clear_fault` → `state`=1 next cycle; `locked` after 4 further good windows. With `AUTORECOVER_EN` defined and no `clear_fault` → ACQUIRE after the first good window, lock after 3 more.
- `clk_mon` held at 0 from the start → `meas_count`=0 every window, `state` stays ACQUIRE, `fault`=0, `locked`=0.
- Drop `enable` at window cycle 500, raise it 10 cycles later → no `meas_valid` for the aborted window; the next `meas_valid` comes 1025 cycles after re-enable; `meas_count` holds its old value until then.
- Assert `reset_n`=0 mid-window while LOCKED → all outputs 0 and `state`=IDLE immediately (asynchronous); after release, the block stays IDLE until `enable` is seen high.
